// File: rtl/div_pkg.sv
// Shared arithmetic package for the sequential divider.
// Holds the default operand width and the FSM state encoding.
package div_pkg;

    localparam int DIV_W = 8;

    // 2'b11 is unused and falls back to IDLE on the next edge.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Request/response bundle for the divider.
// start/eX/Y in; Q/R/busy/done/dbz out.
interface div_if
    import div_pkg::*;
#(
    parameter int W = DIV_W
);

    logic         start;
    logic [W-1:0] eX;
    logic [W-1:0] Y;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         dbz;

    modport master (
        output start, eX, Y,
        input  Q, R, busy, done, dbz
    );

    modport slave (
        input  start, eX, Y,
        output Q, R, busy, done, dbz
    );

endinterface

// File: rtl/div_sub.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract M. Ports: a_i, q_msb_i, m_i -> a_o, q_bit_o.
module div_sub
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   a_i,
    input  logic         q_msb_i,
    input  logic [W-1:0] m_i,
    output logic [W:0]   a_o,
    output logic         q_bit_o
);

    logic [W+1:0] shift_w;
    logic [W+1:0] trial_w;

    // One spare bit on top keeps the borrow unambiguous; since the
    // partial remainder stays below M it matches the W+1-bit sign.
    assign shift_w = {a_i, q_msb_i};
    assign trial_w = shift_w - {2'b00, m_i};

    assign q_bit_o = ~trial_w[W+1];
    assign a_o     = q_bit_o ? trial_w[W:0] : shift_w[W:0];

endmodule

// File: rtl/div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async low), bus (div_if.slave).
module div
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic clk,
    input  logic rst_n,
    div_if.slave bus
);

    localparam int CW = $clog2(W) + 1;

    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]   a_q, a_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] r_q, r_d;
    logic         dbz_q, dbz_d;

    logic [W:0]   sub_a;
    logic         sub_qbit;

    div_sub #(.W(W)) u_sub (
        .a_i     (a_q),
        .q_msb_i (q_q[W-1]),
        .m_i     (m_q),
        .a_o     (sub_a),
        .q_bit_o (sub_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.Y != '0) begin
                        a_d     = '0;
                        q_d     = bus.eX;
                        m_d     = bus.Y;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = STEP;
                    end else begin
                        q_d     = '1;
                        r_d     = bus.eX;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            STEP: begin
                a_d   = sub_a;
                q_d   = {q_q[W-2:0], sub_qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    r_d     = sub_a[W-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.dbz  = dbz_q;
    assign bus.done = (state_q == DONE);
    assign bus.busy = (state_q == STEP) || (state_q == DONE);

endmodule
